// File: rtl/sayac_imm_pkg.sv
// Shared SAYAC move-immediate definitions: opcodes, sequencer states, instruction layout.
package sayac_imm_pkg;

    localparam logic [3:0] OPC_MIL_DEF = 4'hE;
    localparam logic [3:0] OPC_MIH_DEF = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT_LO = 2'd1,
        EMIT_HI = 2'd2
    } state_t;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 0;

    typedef struct packed {
        logic [OPC_MSB-OPC_LSB:0] opc;
        logic [IMM_MSB-IMM_LSB:0] imm8;
        logic [RD_MSB-RD_LSB:0]   rd;
    } instr_t;

    function automatic instr_t pack_instr(input logic [3:0] opc, input logic [7:0] imm8,
                                          input logic [3:0] rd);
        instr_t w;
        w.opc  = opc;
        w.imm8 = imm8;
        w.rd   = rd;
        return w;
    endfunction

endpackage

// File: rtl/imm_fit8.sv
// Flags 16-bit constants that a sign-extended 8-bit immediate reproduces exactly.
// Purely combinational; bits [15:7] must all match the imm8 sign bit.
module imm_fit8 (
    input  logic [15:0] value,
    output logic        fits_se8
);

    assign fits_se8 = (value[15:7] == 9'h000) || (value[15:7] == 9'h1FF);

endmodule

// File: rtl/imm_loader_seq.sv
// Emits the shortest mil / mil+mih stream that loads a 16-bit constant into rd.
// First word valid the cycle after accept; words and state hold while out_ready is low.
module imm_loader_seq
    import sayac_imm_pkg::*;
#(
    parameter logic [3:0] OPC_MIL = OPC_MIL_DEF,
    parameter logic [3:0] OPC_MIH = OPC_MIH_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  in_rd,
    input  logic        in_force2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic        out_last,
    output logic [15:0] words_cnt
);

    state_t      r_state;
    logic [7:0]  r_value_hi;
    logic [3:0]  r_rd;
    logic        r_two;
    instr_t      r_out_instr;
    logic        r_out_last;
    logic [15:0] r_words_cnt;

    state_t      w_state_nxt;
    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_fits;
    logic        w_two_in;
    logic        w_accept;
    logic        w_hs;

    imm_fit8 u_fit (
        .value    (in_value),
        .fits_se8 (w_fits)
    );

    assign w_two_in = in_force2 || !w_fits;
    assign w_accept = in_valid && w_in_ready;
    assign w_hs     = w_out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = EMIT_LO;
                end
            end
            EMIT_LO: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = r_two ? EMIT_HI : IDLE;
                end
            end
            EMIT_HI: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // The mil word is built at accept time, so only the high byte needs to be kept for mih.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_value_hi  <= 8'h00;
            r_rd        <= 4'h0;
            r_two       <= 1'b0;
            r_out_instr <= '0;
            r_out_last  <= 1'b0;
            r_words_cnt <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_value_hi  <= in_value[15:8];
                r_rd        <= in_rd;
                r_two       <= w_two_in;
                r_out_instr <= pack_instr(OPC_MIL, in_value[7:0], in_rd);
                r_out_last  <= !w_two_in;
            end
            if (w_hs) begin
                r_words_cnt <= r_words_cnt + 16'd1;
                if (r_state == EMIT_LO && r_two) begin
                    r_out_instr <= pack_instr(OPC_MIH, r_value_hi, r_rd);
                    r_out_last  <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_instr = r_out_instr;
    assign out_last  = r_out_last;
    assign words_cnt = r_words_cnt;

endmodule
